// File: rtl/key_input_pkg.sv
// Shared types and constants for the pushbutton front end of the LED chaser.
// Key roles are fixed by index: run/pause, direction, speed step, restore defaults.
package key_input_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam logic       RUN_DEFAULT   = 1'b1;
    localparam logic       DIR_DEFAULT   = 1'b0;
    localparam logic [1:0] SPEED_DEFAULT = 2'd0;

    localparam int KEY_RUN      = 0;
    localparam int KEY_DIR      = 1;
    localparam int KEY_SPEED    = 2;
    localparam int KEY_DEFAULTS = 3;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, tick-sampled debounce FSM with a stable
// counter, registered debounced level and a single-cycle press pulse.
//
// state        | meaning
// RELEASED     | key accepted as up
// PRESS_WAIT   | key seen down, counting consecutive down samples
// PRESSED      | key accepted as down
// RELEASE_WAIT | key seen up, counting consecutive up samples
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic tick,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]       sync;
    logic             synced;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Raw key is active-low; flops reset to the released level.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_raw};
        end
    end

    assign synced = ~sync[1];

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (tick) begin
                case (state)
                    RELEASED: begin
                        if (synced) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state <= PRESSED;
                                level <= 1'b1;
                                press <= 1'b1;
                            end else begin
                                state <= PRESS_WAIT;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (synced) begin
                            if (cnt == CNT_LAST) begin
                                state <= PRESSED;
                                cnt   <= '0;
                                level <= 1'b1;
                                press <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!synced) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state <= RELEASED;
                                level <= 1'b0;
                            end else begin
                                state <= RELEASE_WAIT;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        // A bounce back to down keeps the key held and must not re-pulse.
                        if (!synced) begin
                            if (cnt == CNT_LAST) begin
                                state <= RELEASED;
                                cnt   <= '0;
                                level <= 1'b0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_input_ctrl.sv
// Pushbutton front end of the LED chaser: shared debounce tick, one debouncer per key,
// and the run/direction/speed control register driven by accepted presses.
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int TICK_CYCLES    = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int N_KEYS         = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic              run,
    output logic              dir,
    output logic [1:0]        speed
);

    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_debounce (
            .CLOCK_50(CLOCK_50),
            .RESET   (RESET),
            .tick    (tick),
            .key_raw (KEY[i]),
            .level   (key_level[i]),
            .press   (key_press[i])
        );
    end

    // Restore-defaults wins; otherwise the other keys act independently in the same cycle.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            run   <= RUN_DEFAULT;
            dir   <= DIR_DEFAULT;
            speed <= SPEED_DEFAULT;
        end else if (key_press[KEY_DEFAULTS]) begin
            run   <= RUN_DEFAULT;
            dir   <= DIR_DEFAULT;
            speed <= SPEED_DEFAULT;
        end else begin
            if (key_press[KEY_RUN]) begin
                run <= ~run;
            end
            if (key_press[KEY_DIR]) begin
                dir <= ~dir;
            end
            if (key_press[KEY_SPEED]) begin
                speed <= speed + 2'd1;
            end
        end
    end

endmodule

// File: doc/key_input_ctrl.md
Name: key_input_ctrl

Overview:
- Input side of the board LED chaser: reads the four active-low pushbuttons KEY[3:0], synchronises and debounces them, and turns clean presses into control state.
- Control state is run/pause, shift direction and speed select.
- Outputs drive the LED chaser's enable, direction and tick-rate inputs directly.
- Everything runs on CLOCK_50; the debounce sample tick is divided down internally.

Parameters:
- TICK_CYCLES, 50000: CLOCK_50 cycles per debounce sample tick (1 ms at 50 MHz); must be >= 2.
- DEBOUNCE_TICKS, 10: consecutive equal samples needed to accept a level change; must be >= 1.
- N_KEYS, 4: number of KEY inputs; the control mapping uses keys 0..3.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET  input  1  asynchronous, active-high reset.
- KEY  input  N_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
- key_level  output  N_KEYS  debounced level, active-high (1 = held).
- key_press  output  N_KEYS  one-cycle pulse per accepted press.
- run  output  1  1 = chaser advances, 0 = paused.
- dir  output  1  0 = left-to-right, 1 = right-to-left.
- speed  output  2  tick-rate select: 0 = 1 Hz, 1 = 2 Hz, 2 = 4 Hz, 3 = 8 Hz.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - synchroniser flops to 1 (released);
  - tick counter to 0;
  - every key FSM to RELEASED with its stable counter at 0;
  - key_level = 0, key_press = 0;
  - run = 1, dir = 0, speed = 0.
- Synchroniser: two flops per key, then invert to active-high. This gives 2 cycles of latency.
- Tick generator:
  - Counter runs 0..TICK_CYCLES-1 and wraps.
  - tick = 1 for one cycle when the counter equals TICK_CYCLES-1.
- Per-key FSM, advancing only on tick:
  - RELEASED: synced input = 1 → PRESS_WAIT, stable counter = 1. Otherwise stay.
  - PRESS_WAIT: input = 1 → increment the counter; on reaching DEBOUNCE_TICKS → PRESSED. Input = 0 → RELEASED, counter = 0 (glitch rejected).
  - PRESSED: input = 0 → RELEASE_WAIT, counter = 1.
  - RELEASE_WAIT: input = 0 → increment; on reaching DEBOUNCE_TICKS → RELEASED. Input = 1 → PRESSED, counter = 0.
  - With DEBOUNCE_TICKS = 1, RELEASED goes directly to PRESSED on the first sample, and PRESSED goes directly to RELEASED.
- key_level: 1 exactly while the FSM is in PRESSED or RELEASE_WAIT. It is registered and updates in the cycle after the accepting tick.
- key_press: asserted for exactly one CLOCK_50 cycle, the cycle after the tick that enters PRESSED. Releases produce no pulse.
- Control register, updated in the cycle after key_press (one cycle of latency):
  - key_press[0]: run toggles.
  - key_press[1]: dir toggles.
  - key_press[2]: speed increments modulo 4 (3 wraps to 0).
  - key_press[3]: restore defaults (run = 1, dir = 0, speed = 0).
- Simultaneous pulses in the same cycle:
  - key_press[3] overrides all the others.
  - Otherwise keys 0, 1 and 2 apply independently in that same cycle.
- Holding a key produces exactly one pulse; there is no auto-repeat.
- Reset asserted mid-debounce discards any partial count. After release from reset, a key still held needs the full DEBOUNCE_TICKS to be accepted and then produces one pulse.
- Keys with index >= 4 (when N_KEYS > 4) are debounced but do not affect the control register.

Decomposition:
- Shared package key_input_pkg holds:
  - the FSM state typedef (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - the defaults RUN_DEFAULT = 1, DIR_DEFAULT = 0, SPEED_DEFAULT = 2'd0;
  - the key index constants KEY_RUN = 0, KEY_DIR = 1, KEY_SPEED = 2, KEY_DEFAULTS = 3.
- One sub-module, key_debounce:
  - one instance per key, via generate;
  - contains the synchroniser, the FSM and the stable counter;
  - inputs: CLOCK_50, RESET, tick, raw key;
  - outputs: level, press.
- The tick generator and the control register stay in the top level, so all keys share a single tick.

Test Plan (TICK_CYCLES = 4, DEBOUNCE_TICKS = 3):
- Reset: assert RESET mid-cycle with KEY = 4'hF → immediately run = 1, dir = 0, speed = 0, key_level = 0, key_press = 0.
- Clean press: hold KEY[0] = 0 → key_press[0] pulses exactly once, within 3 ticks + 2 sync cycles + 1 (≤ 15 cycles); run goes 1 → 0 one cycle later. Hold for 100 cycles → no further pulse, key_level[0] stays 1.
- Glitch rejection: drive KEY[1] low for 2 ticks then high → no key_press[1], dir stays 0. Bounce 0/1/0 on consecutive ticks then hold 0 → exactly one pulse, dir = 1.
- Speed wrap: five separate presses of KEY[2] → speed steps 1, 2, 3, 0, 1.
- Priority: after dir = 1 and speed = 2, press KEY[0] and KEY[3] so that both key_press pulses land in the same cycle → run = 1, dir = 0, speed = 0 (defaults win).
- Reset mid-debounce: hold KEY[0] low, assert RESET after 2 ticks, release it → no pulse until 3 full ticks after release, then exactly one pulse and run = 0.
